// File: rtl/synth_core_harness_if.sv
// Operand/result bus between the stimulus harness and a synthetic core.
interface synth_core_harness_if #(
    parameter int W = 32
);
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic [W-1:0] core_c;
    logic         core_sel;
    logic [W-1:0] core_result;

    // Harness side: drives operands, receives the registered result.
    modport master (
        output core_a,
        output core_b,
        output core_c,
        output core_sel,
        input  core_result
    );

    // Core side: receives operands, returns the result.
    modport slave (
        input  core_a,
        input  core_b,
        input  core_c,
        input  core_sel,
        output core_result
    );
endinterface

// File: rtl/synth_core_harness.sv
// Stimulus driver and response checker for the synthetic datapath cores.
// Drives LFSR-derived operand vectors, carries the expected result through a
// latency-matched delay line and records mismatches for the host.
module synth_core_harness #(
    parameter int          W    = 32,
    parameter int          LAT  = 1,
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          num_vec,
    input  logic [1:0]           mode,
    synth_core_harness_if.master core_if,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [15:0]          first_err_idx,
    output logic [W-1:0]         first_err_got,
    output logic [W-1:0]         first_err_exp
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_DRIVE = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int unsigned LAT_U     = LAT;

    logic [1:0]   r_state;
    logic [31:0]  r_lfsr;
    logic [15:0]  r_num;
    logic [1:0]   r_mode;
    logic [15:0]  r_idx;

    logic [W-1:0] r_core_a;
    logic [W-1:0] r_core_b;
    logic [W-1:0] r_core_c;
    logic         r_core_sel;

    // Entry 0 is loaded on the same edge as the core operands; entry LAT is
    // compared against the core result sampled LAT cycles after that drive.
    logic [LAT:0] r_dvld;
    logic [W-1:0] r_dexp [0:LAT];
    logic [15:0]  r_didx [0:LAT];

    logic [31:0]  w_lfsr_next;
    logic [31:0]  w_rot;
    logic [31:0]  w_inv;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_c;
    logic         w_sel;
    logic [W-1:0] w_exp;
    logic         w_accept;
    logic         w_pending;
    logic         w_mis;
    logic [15:0]  w_err_next;

    assign core_if.core_a   = r_core_a;
    assign core_if.core_b   = r_core_b;
    assign core_if.core_c   = r_core_c;
    assign core_if.core_sel = r_core_sel;

    // A start landing on the done-pulse cycle is dropped so the host re-issues it.
    assign w_accept = (r_state == S_IDLE) && start && !done;

    // Galois LFSR step, operand derivation and expected-model result.
    always_comb begin
        w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
        w_rot       = {r_lfsr[20:0], r_lfsr[31:21]};
        w_inv       = ~r_lfsr;
        w_a         = r_lfsr[W-1:0];
        w_b         = w_rot[W-1:0];
        w_c         = w_inv[W-1:0];
        w_sel       = r_lfsr[31];
        w_exp       = '0;
        case (r_mode)
            2'd0:    w_exp = '0;
            2'd1:    w_exp = w_a + w_c;
            2'd2:    w_exp = w_sel ? w_b : w_c;
            default: w_exp = w_a ^ w_b;
        endcase
    end

    // Drain is finished once only the entry about to be checked remains in flight.
    always_comb begin
        w_pending = 1'b0;
        for (int unsigned i = 0; i + 1 < LAT_U; i++) begin
            w_pending = w_pending | r_dvld[i];
        end
    end

    // Mismatch detection and the saturating next error count.
    always_comb begin
        w_mis      = r_dvld[LAT] && (core_if.core_result != r_dexp[LAT]);
        w_err_next = err_count;
        if (w_mis && (err_count != 16'hFFFF)) begin
            w_err_next = err_count + 16'd1;
        end
    end

    // Run-control FSM, generator stepping and registered core operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED_EFF;
            r_num      <= '0;
            r_mode     <= '0;
            r_idx      <= '0;
            r_core_a   <= '0;
            r_core_b   <= '0;
            r_core_c   <= '0;
            r_core_sel <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_core_a   <= '0;
            r_core_b   <= '0;
            r_core_c   <= '0;
            r_core_sel <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num   <= num_vec;
                        r_mode  <= mode;
                        r_lfsr  <= SEED_EFF;
                        r_idx   <= '0;
                        pass    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= (num_vec == 16'd0) ? S_DONE : S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_core_a   <= w_a;
                    r_core_b   <= w_b;
                    r_core_c   <= w_c;
                    r_core_sel <= w_sel;
                    r_lfsr     <= w_lfsr_next;
                    r_idx      <= r_idx + 16'd1;
                    if (r_idx == r_num - 16'd1) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!w_pending) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // The final vector is checked on this edge, so pass uses the updated count.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pass    <= (w_err_next == 16'd0);
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Expected-result delay line, aligned with the core latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvld <= '0;
            for (int unsigned i = 0; i <= LAT_U; i++) begin
                r_dexp[i] <= '0;
                r_didx[i] <= '0;
            end
        end else begin
            r_dvld[0] <= (r_state == S_DRIVE);
            r_dexp[0] <= w_exp;
            r_didx[0] <= r_idx;
            for (int unsigned i = 1; i <= LAT_U; i++) begin
                r_dvld[i] <= r_dvld[i-1];
                r_dexp[i] <= r_dexp[i-1];
                r_didx[i] <= r_didx[i-1];
            end
        end
    end

    // Error counting and first-mismatch capture; cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (w_accept) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (w_mis) begin
            err_count <= w_err_next;
            if (err_count == 16'd0) begin
                first_err_idx <= r_didx[LAT];
                first_err_got <= core_if.core_result;
                first_err_exp <= r_dexp[LAT];
            end
        end
    end
endmodule
